// File: rtl/tankdrive_pkg.sv
// Shared encodings for the tank-drive controller: bridge modes and channel FSM states.
package tankdrive_pkg;

  typedef enum logic [1:0] {
    MODE_COAST = 2'b00,
    MODE_FWD   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_BRAKE = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BRAKE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_RAMPDN = 3'd3,
    ST_DEAD   = 3'd4
  } chan_state_e;

endpackage

// File: rtl/tankdrive_chan.sv
// One motor channel: duty ramping, direction-reversal sequencing and registered bridge outputs.
//   state     | meaning
//   ST_IDLE   | coasting, bridge off, duty 0
//   ST_BRAKE  | bridge shorted (enable=1), duty 0
//   ST_RUN    | driving, duty ramps toward commanded speed at period boundaries
//   ST_RAMPDN | reversal requested, duty ramps to 0 in the old direction
//   ST_DEAD   | forced coast for DEADTIME whole periods before the new direction
module tankdrive_chan
  import tankdrive_pkg::*;
#(
  parameter int SPEED_W   = 6,
  parameter int RAMP_STEP = 8,
  parameter int DEADTIME  = 2
) (
  input  logic               i_sysclk,
  input  logic               i_reset,
  input  logic               i_boundary,
  input  logic [SPEED_W-1:0] i_pwm_cnt,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [1:0]         i_mode,
  output logic               o_enable,
  output logic [1:0]         o_mode_out,
  output logic               o_settled
);

  localparam int MAX_DUTY = 2**SPEED_W - 1;
  localparam int STEP_CLIP = (RAMP_STEP > MAX_DUTY) ? MAX_DUTY : RAMP_STEP;
  localparam logic [SPEED_W-1:0] STEP = STEP_CLIP[SPEED_W-1:0];
  localparam int DW = $clog2(DEADTIME + 2);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEADTIME);

  chan_state_e        r_state;
  logic [SPEED_W-1:0] r_cur;
  logic [DW-1:0]      r_dead;
  logic [1:0]         r_mode_out;
  logic               r_enable;
  logic               r_settled;

  logic               w_same;
  logic [SPEED_W-1:0] w_tgt;
  logic [SPEED_W-1:0] w_ramp;
  logic [SPEED_W-1:0] w_ramp_up;

  // Step limited to min(STEP, distance) so the result never wraps.
  function automatic logic [SPEED_W-1:0] ramp_toward(input logic [SPEED_W-1:0] cur,
                                                      input logic [SPEED_W-1:0] tgt);
    logic [SPEED_W-1:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > STEP) ? cur + STEP : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > STEP) ? cur - STEP : tgt;
    end
  endfunction

  assign w_same    = (i_mode == r_mode_out);
  assign w_tgt     = w_same ? i_speed : '0;
  assign w_ramp    = ramp_toward(r_cur, w_tgt);
  assign w_ramp_up = ramp_toward('0, i_speed);

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_dead     <= '0;
      r_mode_out <= MODE_COAST;
      r_enable   <= 1'b0;
      r_settled  <= 1'b1;
    end else if (i_mode == MODE_BRAKE) begin
      r_state    <= ST_BRAKE;
      r_cur      <= '0;
      r_dead     <= '0;
      r_mode_out <= MODE_BRAKE;
      r_enable   <= 1'b1;
      r_settled  <= 1'b1;
    end else if (i_mode == MODE_COAST) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_dead     <= '0;
      r_mode_out <= MODE_COAST;
      r_enable   <= 1'b0;
      r_settled  <= 1'b1;
    end else begin
      r_enable  <= (i_pwm_cnt < r_cur);
      r_settled <= (r_state == ST_IDLE) || (r_state == ST_BRAKE) ||
                   ((r_state == ST_RUN) && w_same && (r_cur == i_speed));
      case (r_state)
        ST_IDLE, ST_BRAKE: begin
          r_state    <= ST_RUN;
          r_mode_out <= i_mode;
          r_cur      <= '0;
        end
        ST_RUN: begin
          if (i_boundary) r_cur <= w_ramp;
          if (!w_same) r_state <= ST_RAMPDN;
        end
        ST_RAMPDN: begin
          if (w_same) begin
            r_state <= ST_RUN;
            if (i_boundary) r_cur <= w_ramp;
          end else if (i_boundary) begin
            if (r_cur == '0) begin
              r_state    <= ST_DEAD;
              r_mode_out <= MODE_COAST;
              r_dead     <= DEAD_INIT;
            end else begin
              r_cur <= w_ramp;
            end
          end
        end
        ST_DEAD: begin
          // Exit takes whatever direction is commanded now, not the one that started the reversal.
          if (i_boundary) begin
            if (r_dead <= DW'(1)) begin
              r_state    <= ST_RUN;
              r_mode_out <= i_mode;
              r_cur      <= w_ramp_up;
              r_dead     <= '0;
            end else begin
              r_dead <= r_dead - DW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_enable   = r_enable;
  assign o_mode_out = r_mode_out;
  assign o_settled  = r_settled;

endmodule

// File: rtl/tankdrive_multi.sv
// Multi-channel tank-drive PWM controller: shared prescaler and PWM counter feeding per-channel FSMs.
module tankdrive_multi
  import tankdrive_pkg::*;
#(
  parameter int SPEED_W   = 6,
  parameter int CHANNELS  = 2,
  parameter int PRESCALE  = 1,
  parameter int RAMP_STEP = 8,
  parameter int DEADTIME  = 2
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [CHANNELS*SPEED_W-1:0]   speed,
  input  logic [CHANNELS*2-1:0]         mode,
  output logic [CHANNELS-1:0]           enable,
  output logic [CHANNELS*2-1:0]         mode_out,
  output logic [CHANNELS-1:0]           settled
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [SPEED_W-1:0] CNT_LAST = SPEED_W'(2**SPEED_W - 2);

  logic [PW-1:0]      r_pre;
  logic [SPEED_W-1:0] r_pwm_cnt;
  logic               w_tick;
  logic               w_boundary;

  assign w_tick     = (r_pre == PRE_LAST);
  // Boundary is the cycle whose edge wraps the PWM counter back to 0.
  assign w_boundary = w_tick && (r_pwm_cnt == CNT_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) r_pwm_cnt <= (r_pwm_cnt == CNT_LAST) ? '0 : r_pwm_cnt + SPEED_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    tankdrive_chan #(
      .SPEED_W  (SPEED_W),
      .RAMP_STEP(RAMP_STEP),
      .DEADTIME (DEADTIME)
    ) u_chan (
      .i_sysclk  (sysclk),
      .i_reset   (reset),
      .i_boundary(w_boundary),
      .i_pwm_cnt (r_pwm_cnt),
      .i_speed   (speed[g*SPEED_W +: SPEED_W]),
      .i_mode    (mode[2*g +: 2]),
      .o_enable  (enable[g]),
      .o_mode_out(mode_out[2*g +: 2]),
      .o_settled (settled[g])
    );
  end

endmodule

// File: tb/tb_tankdrive_multi.sv
// Directed bench for tankdrive_multi: per-period vector table plus brake, coast and reset sequences.
module tb_tankdrive_multi;

  localparam int PERIOD = 63;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [11:0] speed  = '0;
  logic [3:0]  mode   = '0;
  logic [1:0]  enable;
  logic [3:0]  mode_out;
  logic [1:0]  settled;

  int cyc;
  int n_pass;
  int n_total;
  int h0, h1, mo0, mo1, st;

  typedef struct {
    logic [1:0] m0;
    int         s0;
    logic [1:0] m1;
    int         s1;
    int         hi0;
    logic [1:0] mo0;
    bit         set0;
    int         hi1;
    logic [1:0] mo1;
    bit         set1;
  } vec_t;

  vec_t tbl[16];

  tankdrive_multi #(
    .SPEED_W(6), .CHANNELS(2), .PRESCALE(1), .RAMP_STEP(8), .DEADTIME(2)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .speed   (speed),
    .mode    (mode),
    .enable  (enable),
    .mode_out(mode_out),
    .settled (settled)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input int s);
    mode[2*ch +: 2]  = m;
    speed[6*ch +: 6] = 6'(s);
  endtask

  task automatic to_boundary();
    while (cyc % PERIOD != 0) tick();
  endtask

  // One PWM period window starting just after a boundary edge.
  task automatic run_period(output int hi0, output int hi1, output int mo_0,
                            output int mo_1, output int st_end);
    hi0 = 0;
    hi1 = 0;
    mo_0 = 0;
    mo_1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (i == 0) begin
        mo_0 = int'(mode_out[1:0]);
        mo_1 = int'(mode_out[3:2]);
      end
      hi0 += int'(enable[0]);
      hi1 += int'(enable[1]);
    end
    st_end = int'(settled);
  endtask

  task automatic do_reset(input bit rnd);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rnd) begin
        speed = 12'($urandom);
        mode  = 4'($urandom);
      end
      tick();
      check($sformatf("reset%0d enable", i), int'(enable), 0);
      check($sformatf("reset%0d mode_out", i), int'(mode_out), 0);
    end
    check("reset settled", int'(settled), 3);
    reset = 1'b0;
    check("reset pwm_cnt", int'(dut.r_pwm_cnt), 0);
    cyc = 0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;

    //           m0     s0  m1     s1  hi0 mo0   st0   hi1 mo1   st1
    tbl[0]  = '{2'b01, 32, 2'b00, 20,  0, 2'b01, 1'b0,  0, 2'b00, 1'b1};
    tbl[1]  = '{2'b01, 32, 2'b00, 20,  8, 2'b01, 1'b0,  0, 2'b00, 1'b1};
    tbl[2]  = '{2'b01, 32, 2'b00, 20, 16, 2'b01, 1'b0,  0, 2'b00, 1'b1};
    tbl[3]  = '{2'b01, 32, 2'b00, 20, 24, 2'b01, 1'b0,  0, 2'b00, 1'b1};
    tbl[4]  = '{2'b01, 32, 2'b00, 20, 32, 2'b01, 1'b1,  0, 2'b00, 1'b1};
    tbl[5]  = '{2'b10, 32, 2'b10, 20, 32, 2'b01, 1'b0,  0, 2'b10, 1'b0};
    tbl[6]  = '{2'b10, 32, 2'b10, 20, 24, 2'b01, 1'b0,  8, 2'b10, 1'b0};
    tbl[7]  = '{2'b10, 32, 2'b10, 20, 16, 2'b01, 1'b0, 16, 2'b10, 1'b0};
    tbl[8]  = '{2'b10, 32, 2'b10, 20,  8, 2'b01, 1'b0, 20, 2'b10, 1'b1};
    tbl[9]  = '{2'b10, 32, 2'b10, 20,  0, 2'b01, 1'b0, 20, 2'b10, 1'b1};
    tbl[10] = '{2'b10, 32, 2'b10, 20,  0, 2'b00, 1'b0, 20, 2'b10, 1'b1};
    tbl[11] = '{2'b10, 32, 2'b10, 20,  0, 2'b00, 1'b0, 20, 2'b10, 1'b1};
    tbl[12] = '{2'b10, 32, 2'b10,  5,  8, 2'b10, 1'b0, 20, 2'b10, 1'b0};
    tbl[13] = '{2'b10, 32, 2'b10,  5, 16, 2'b10, 1'b0, 12, 2'b10, 1'b0};
    tbl[14] = '{2'b10, 32, 2'b10,  5, 24, 2'b10, 1'b0,  5, 2'b10, 1'b1};
    tbl[15] = '{2'b10, 32, 2'b10,  5, 32, 2'b10, 1'b1,  5, 2'b10, 1'b1};

    // Reset with random inputs, then the period-by-period table.
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      set_ch(0, tbl[i].m0, tbl[i].s0);
      set_ch(1, tbl[i].m1, tbl[i].s1);
      run_period(h0, h1, mo0, mo1, st);
      check($sformatf("row%0d hi0", i), h0, tbl[i].hi0);
      check($sformatf("row%0d mode_out0", i), mo0, int'(tbl[i].mo0));
      check($sformatf("row%0d settled0", i), st & 1, int'(tbl[i].set0));
      check($sformatf("row%0d hi1", i), h1, tbl[i].hi1);
      check($sformatf("row%0d mode_out1", i), mo1, int'(tbl[i].mo1));
      check($sformatf("row%0d settled1", i), (st >> 1) & 1, int'(tbl[i].set1));
    end

    // Full-scale ramp: duty saturates at 63, i.e. constant high.
    set_ch(0, 2'b00, 0);
    set_ch(1, 2'b00, 0);
    do_reset(1'b0);
    set_ch(0, 2'b01, 63);
    for (int p = 0; p < 10; p++) begin
      run_period(h0, h1, mo0, mo1, st);
      check($sformatf("full p%0d hi0", p), h0, (8 * p > 63) ? 63 : 8 * p);
      check($sformatf("full p%0d hi1", p), h1, 0);
    end

    // Brake mid-ramp, release into forward (no dead time), then coast.
    set_ch(0, 2'b00, 0);
    do_reset(1'b0);
    set_ch(0, 2'b01, 32);
    for (int p = 0; p < 3; p++) begin
      run_period(h0, h1, mo0, mo1, st);
      check($sformatf("pre-brake p%0d hi0", p), h0, 8 * p);
    end
    repeat (10) tick();
    set_ch(0, 2'b11, 32);
    tick();
    check("brake mode_out0", int'(mode_out[1:0]), 3);
    check("brake enable0", int'(enable[0]), 1);
    h0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      h0 += int'(enable[0]);
    end
    check("brake hold enable0", h0, 20);
    set_ch(0, 2'b01, 32);
    tick();
    check("unbrake mode_out0", int'(mode_out[1:0]), 1);
    check("unbrake enable0", int'(enable[0]), 0);
    to_boundary();
    run_period(h0, h1, mo0, mo1, st);
    check("unbrake p0 hi0", h0, 8);
    check("unbrake p0 mode_out0", mo0, 1);
    run_period(h0, h1, mo0, mo1, st);
    check("unbrake p1 hi0", h0, 16);
    repeat (5) tick();
    set_ch(0, 2'b00, 32);
    tick();
    check("coast mode_out0", int'(mode_out[1:0]), 0);
    check("coast enable0", int'(enable[0]), 0);
    check("coast settled0", int'(settled[0]), 1);

    // Reset in dead time discards the pending reversal.
    do_reset(1'b0);
    set_ch(0, 2'b01, 32);
    for (int p = 0; p < 5; p++) run_period(h0, h1, mo0, mo1, st);
    set_ch(0, 2'b10, 32);
    for (int p = 0; p < 5; p++) run_period(h0, h1, mo0, mo1, st);
    repeat (20) tick();
    check("dead mode_out0", int'(mode_out[1:0]), 0);
    check("dead settled0", int'(settled[0]), 0);
    do_reset(1'b0);
    set_ch(0, 2'b01, 32);
    tick();
    check("post-reset mode_out0", int'(mode_out[1:0]), 1);
    to_boundary();
    run_period(h0, h1, mo0, mo1, st);
    check("post-reset p1 hi0", h0, 8);
    check("post-reset p1 mode_out0", mo0, 1);
    run_period(h0, h1, mo0, mo1, st);
    check("post-reset p2 hi0", h0, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
